decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV32E instruction decoder; sits directly downstream of the fetch stage.
//  - Accepts raw 32-bit instruction words on a valid/ready skid-buffer port.
//  - Splits each word into register indices, a sign-extended immediate and an
//    op class, and flags illegal encodings.
//  - Presents one registered decoded bundle per instruction to execute, with
//    full backpressure and flush support.
// PARAMETERS
//  XLEN          32   datapath/immediate width
//  REG_IDX_W     4    register index width (RV32E: x0..x15)
// PORTS
//  clock         in   1     clock
//  reset         in   1     reset, asynchronous, active-low
//  flush         in   1     discard all held/in-flight instructions (branch redirect)
//  in_valid      in   1     fetch presents instruction
//  in_ready      out  1     decode can accept instruction this cycle
//  in_data       in   32    raw instruction word
//  out_valid     out  1     decoded bundle valid
//  out_ready     in   1     execute accepts bundle
//  out_class     out  4     op_class_t (LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP_IMM,OP,SYSTEM,FENCE)
//  out_rd        out  4     destination register
//  out_rs1       out  4     source register 1
//  out_rs2       out  4     source register 2
//  out_funct3    out  3     funct3 field
//  out_funct7b5  out  1     instr[30] (SUB/SRA select)
//  out_imm       out  32    sign-extended immediate (format per class; 0 for R-type)
//  out_illegal   out  1     illegal encoding; bundle still delivered, execute traps
// BEHAVIOUR
//  Reset: out_valid=0; in_ready=1; all out_* data fields=0; skid entry empty.
//  Handshakes:
//   - Transfer occurs when valid&&ready at a clock edge, on either port.
//   - out_valid, once high, holds with stable data until out_ready.
//   - in_data is only sampled on an input transfer.
//  Latency: 1 cycle; an input transfer at edge N gives out_valid at edge N+1
//   when the output register is free or draining.
//  Storage: output register (main) plus one skid entry.
//   - in_ready = !skid_full, registered; no combinational in->out ready path.
//   - Input transfer while main is full and not draining -> word goes to skid.
//   - Main drains (out_ready) with skid full -> skid moves into main; in_ready
//     rises the next cycle.
//   - Simultaneous input + output transfer with skid empty -> main reloads
//     directly, no bubble.
//   - Order is strictly preserved; no drop, no duplication.
//   - Skid holds the raw word; decode logic sits in front of main and is fed
//     from skid when skid is full, else from in_data.
//  Decode rules:
//   - Opcode [6:0] maps to class; any other opcode -> illegal.
//   - Immediates per format:
//       I = {{20{i[31]}},i[31:20]}
//       S = {{20{i[31]}},i[31:25],i[11:7]}
//       B = {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}
//       U = {i[31:12],12'b0}
//       J = {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}
//   - illegal also set when:
//     - any used register field has bit 4 set (x16..x31);
//     - i[1:0] != 2'b11 (compressed);
//     - OP with funct7 not in {0x00,0x20};
//     - funct7=0x20 with funct3 not in {ADD/SUB, SR};
//     - OP_IMM shift with bad funct7.
//   - Register outputs take the low 4 bits of each field; unused fields are
//     passed through.
//  Flush:
//   - Synchronous; clears main and skid valid at the edge; in_ready=1 the
//     next cycle.
//   - An input transfer in the flush cycle is discarded; flush has priority
//     over all transfers.
//  Reset mid-operation: asynchronously returns to the reset state; held
//   instructions are lost.
//  No FSM beyond the two valid bits: {main_v,skid_v} in {00,10,11}; 01 is
//   unreachable and is asserted against.
// STRUCTURE
//  Package core_pkg:
//   - opcode localparams (OPC_LUI=7'b0110111, ...)
//   - op_class_t enum
//   - decoded_t struct {class,rd,rs1,rs2,funct3,funct7b5,imm,illegal}
//  Sub-module: instr_decoder (pure combinational word -> decoded_t), used once
//   before the main register.
//  Skid/main control and registers stay in decode_stage.
// TESTING
//  1 ADDI x1,x0,5 (0x00500093), out_ready=1:
//    -> next cycle class=OP_IMM rd=1 rs1=0 imm=5 illegal=0.
//  2 ADDI x1,x0,-1 (0xFFF00093) -> imm=0xFFFFFFFF.
//    BEQ x0,x0,-4 (0xFE000EE3) -> class=BRANCH imm=0xFFFFFFFC.
//  3 ADD x16,x0,x0 (0x00000833) -> illegal=1, delivered.
//    0x0000_0001 (compressed) -> illegal=1.
//  4 out_ready=0 for 4 cycles, 3 words offered back-to-back:
//    -> in_ready=0 after the second is accepted; release gives 3 outputs in
//       order, none lost.
//  5 Main+skid full, flush=1 with in_valid=1 -> next cycle out_valid=0,
//    in_ready=1; nothing from the flushed words is ever emitted.
//  6 reset low mid-stall -> out_valid=0 and in_ready=1 immediately
//    (asynchronous); first instruction after release decodes normally.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32E decode types: opcodes, op classes and the decoded bundle.
package core_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SR      = 3'b101;

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_OP_IMM  = 4'd7,
        CLS_OP      = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_FENCE   = 4'd10,
        CLS_ILLEGAL = 4'd11
    } op_class_t;

    typedef struct packed {
        op_class_t              cls;
        logic [REG_IDX_W-1:0]   rd;
        logic [REG_IDX_W-1:0]   rs1;
        logic [REG_IDX_W-1:0]   rs2;
        logic [2:0]             funct3;
        logic                   funct7b5;
        logic [XLEN-1:0]        imm;
        logic                   illegal;
    } decoded_t;

endpackage

// File: rtl/instr_decoder.sv
// Purpose: pure combinational RV32E word -> decoded_t split with illegal detection.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller owns all flow control.
module instr_decoder
    import core_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output decoded_t        dec
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic            use_rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            bad_enc;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec          = '0;
        dec.cls      = CLS_ILLEGAL;
        dec.rd       = instr[10:7];
        dec.rs1      = instr[18:15];
        dec.rs2      = instr[23:20];
        dec.funct3   = f3;
        dec.funct7b5 = instr[30];
        use_rd       = 1'b0;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        bad_enc      = 1'b0;

        case (opcode)
            OPC_LUI:    begin dec.cls = CLS_LUI;    dec.imm = imm_u; use_rd = 1'b1; end
            OPC_AUIPC:  begin dec.cls = CLS_AUIPC;  dec.imm = imm_u; use_rd = 1'b1; end
            OPC_JAL:    begin dec.cls = CLS_JAL;    dec.imm = imm_j; use_rd = 1'b1; end
            OPC_JALR:   begin dec.cls = CLS_JALR;   dec.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1; end
            OPC_BRANCH: begin dec.cls = CLS_BRANCH; dec.imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_LOAD:   begin dec.cls = CLS_LOAD;   dec.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1; end
            OPC_STORE:  begin dec.cls = CLS_STORE;  dec.imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_OP_IMM: begin
                dec.cls = CLS_OP_IMM;
                dec.imm = imm_i;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                // Only shifts reuse the upper immediate bits as funct7.
                if (f3 == F3_SLL && f7 != F7_BASE)
                    bad_enc = 1'b1;
                if (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT)
                    bad_enc = 1'b1;
            end
            OPC_OP: begin
                dec.cls = CLS_OP;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (f7 != F7_BASE && f7 != F7_ALT)
                    bad_enc = 1'b1;
                if (f7 == F7_ALT && f3 != F3_ADD_SUB && f3 != F3_SR)
                    bad_enc = 1'b1;
            end
            OPC_SYSTEM: begin
                dec.cls = CLS_SYSTEM;
                dec.imm = imm_i;
                use_rd  = 1'b1;
                // CSR immediate forms carry a zimm in the rs1 slot.
                use_rs1 = ~f3[2];
            end
            OPC_FENCE:  begin dec.cls = CLS_FENCE;  dec.imm = imm_i; end
            default:    bad_enc = 1'b1;
        endcase

        dec.illegal = bad_enc
                    | (instr[1:0] != 2'b11)
                    | (use_rd  & instr[11])
                    | (use_rs1 & instr[19])
                    | (use_rs2 & instr[24]);
    end

endmodule

// File: rtl/decode_stage.sv
// Purpose: registered RV32E decode stage with a one-entry raw-word skid buffer.
// Latency: 1 cycle from input transfer to out_valid when main is free or draining.
// Backpressure: in_ready is registered (!skid full); no combinational ready path.
module decode_stage
    import core_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_class,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic [REG_IDX_W-1:0] out_rs1,
    output logic [REG_IDX_W-1:0] out_rs2,
    output logic [2:0]           out_funct3,
    output logic                 out_funct7b5,
    output logic [XLEN-1:0]      out_imm,
    output logic                 out_illegal
);

    logic            main_v;
    logic            skid_v;
    decoded_t        main_q;
    logic [XLEN-1:0] skid_q;
    logic [XLEN-1:0] dec_word;
    decoded_t        dec;
    logic            in_fire;

    assign in_fire  = in_valid && !skid_v;
    assign dec_word = skid_v ? skid_q : in_data;

    instr_decoder u_instr_decoder (
        .instr (dec_word),
        .dec   (dec)
    );

    // skid_v implies main_v, so out_ready alone marks a drain whenever skid is full.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            if (out_ready) begin
                main_q <= dec;
                skid_v <= 1'b0;
            end
        end else if (in_fire) begin
            if (!main_v || out_ready) begin
                main_q <= dec;
                main_v <= 1'b1;
            end else begin
                skid_q <= in_data;
                skid_v <= 1'b1;
            end
        end else if (out_ready) begin
            main_v <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            assert (main_v || !skid_v);
    end

    assign in_ready     = !skid_v;
    assign out_valid    = main_v;
    assign out_class    = main_q.cls;
    assign out_rd       = main_q.rd;
    assign out_rs1      = main_q.rs1;
    assign out_rs2      = main_q.rs2;
    assign out_funct3   = main_q.funct3;
    assign out_funct7b5 = main_q.funct7b5;
    assign out_imm      = main_q.imm;
    assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases then random traffic against a queue/occupancy model.
module tb_decode_stage;
    import core_pkg::*;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_class;
    logic [3:0]  out_rd;
    logic [3:0]  out_rs1;
    logic [3:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic [31:0] out_imm;
    logic        out_illegal;

    int compared   = 0;
    int mismatched = 0;
    int emitted    = 0;
    decoded_t model_q[$];

    decode_stage dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_class    (out_class),
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_funct3   (out_funct3),
        .out_funct7b5 (out_funct7b5),
        .out_imm      (out_imm),
        .out_illegal  (out_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decode written directly from the instruction-set tables.
    function automatic decoded_t ref_decode(input logic [31:0] w);
        decoded_t   d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit urd, urs1, urs2, bad;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        urd = 0; urs1 = 0; urs2 = 0; bad = 0;
        d = '0;
        d.cls = CLS_ILLEGAL;
        d.rd = w[10:7]; d.rs1 = w[18:15]; d.rs2 = w[23:20];
        d.funct3 = f3; d.funct7b5 = w[30];
        case (op)
            7'b0110111: begin d.cls = CLS_LUI;   d.imm = {w[31:12], 12'h000}; urd = 1; end
            7'b0010111: begin d.cls = CLS_AUIPC; d.imm = {w[31:12], 12'h000}; urd = 1; end
            7'b1101111: begin d.cls = CLS_JAL;
                d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; urd = 1; end
            7'b1100111: begin d.cls = CLS_JALR;  d.imm = {{20{w[31]}}, w[31:20]}; urd = 1; urs1 = 1; end
            7'b1100011: begin d.cls = CLS_BRANCH;
                d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; urs1 = 1; urs2 = 1; end
            7'b0000011: begin d.cls = CLS_LOAD;  d.imm = {{20{w[31]}}, w[31:20]}; urd = 1; urs1 = 1; end
            7'b0100011: begin d.cls = CLS_STORE;
                d.imm = {{20{w[31]}}, w[31:25], w[11:7]}; urs1 = 1; urs2 = 1; end
            7'b0010011: begin d.cls = CLS_OP_IMM; d.imm = {{20{w[31]}}, w[31:20]}; urd = 1; urs1 = 1;
                if (f3 == 3'd1 && f7 != 7'h00) bad = 1;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) bad = 1; end
            7'b0110011: begin d.cls = CLS_OP; urd = 1; urs1 = 1; urs2 = 1;
                if (f7 != 7'h00 && f7 != 7'h20) bad = 1;
                if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) bad = 1; end
            7'b1110011: begin d.cls = CLS_SYSTEM; d.imm = {{20{w[31]}}, w[31:20]}; urd = 1; urs1 = !f3[2]; end
            7'b0001111: begin d.cls = CLS_FENCE;  d.imm = {{20{w[31]}}, w[31:20]}; end
            default: bad = 1;
        endcase
        d.illegal = bad || (w[1:0] != 2'b11) || (urd && w[11]) || (urs1 && w[19]) || (urs2 && w[24]);
        return d;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 12);
        case (k)
            0:  w[6:0] = 7'b0110111;
            1:  w[6:0] = 7'b0010111;
            2:  w[6:0] = 7'b1101111;
            3:  w[6:0] = 7'b1100111;
            4:  w[6:0] = 7'b1100011;
            5:  w[6:0] = 7'b0000011;
            6:  w[6:0] = 7'b0100011;
            7:  w[6:0] = 7'b0010011;
            8:  w[6:0] = 7'b0110011;
            9:  w[6:0] = 7'b1110011;
            10: w[6:0] = 7'b0001111;
            default: ;
        endcase
        if ($urandom_range(0, 3) != 0) begin
            w[11] = 1'b0; w[19] = 1'b0; w[24] = 1'b0;
        end
        if ((k == 7 || k == 8) && $urandom_range(0, 3) != 0)
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    // Model: in-flight words kept in order; capacity two (main + skid).
    task automatic check_model();
        decoded_t e;
        chk("out_valid", {31'b0, out_valid}, {31'b0, model_q.size() > 0});
        chk("in_ready", {31'b0, in_ready}, {31'b0, model_q.size() < 2});
        if (model_q.size() > 0) begin
            e = model_q[0];
            chk("class", {28'b0, out_class}, {28'b0, e.cls});
            chk("rd", {28'b0, out_rd}, {28'b0, e.rd});
            chk("rs1", {28'b0, out_rs1}, {28'b0, e.rs1});
            chk("rs2", {28'b0, out_rs2}, {28'b0, e.rs2});
            chk("funct3", {29'b0, out_funct3}, {29'b0, e.funct3});
            chk("funct7b5", {31'b0, out_funct7b5}, {31'b0, e.funct7b5});
            chk("imm", out_imm, e.imm);
            chk("illegal", {31'b0, out_illegal}, {31'b0, e.illegal});
        end
    endtask

    task automatic step(input logic vld, input logic [31:0] dat, input logic ordy, input logic fl);
        bit in_f, out_f;
        in_valid = vld; in_data = dat; out_ready = ordy; flush = fl;
        in_f  = vld && (model_q.size() < 2);
        out_f = ordy && (model_q.size() > 0);
        if (fl) model_q.delete();
        else begin
            if (out_f) begin void'(model_q.pop_front()); emitted++; end
            if (in_f) model_q.push_back(ref_decode(dat));
        end
        @(posedge clock);
        @(negedge clock);
        check_model();
    endtask

    initial begin
        logic        pend, ordy, fl, acc;
        logic [31:0] pw;
        bit          w3_acc;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_fields", {16'b0, out_class, out_rd, out_rs1, out_rs2}, 32'd0);
        chk("rst_misc", {27'b0, out_funct3, out_funct7b5, out_illegal}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // ADDI x1,x0,5
        step(1, 32'h00500093, 1, 0);
        chk("t1_class", {28'b0, out_class}, {28'b0, CLS_OP_IMM});
        chk("t1_rd", {28'b0, out_rd}, 32'd1);
        chk("t1_rs1", {28'b0, out_rs1}, 32'd0);
        chk("t1_imm", out_imm, 32'd5);
        chk("t1_illegal", {31'b0, out_illegal}, 32'd0);

        step(1, 32'hFFF00093, 1, 0);
        chk("t2_imm_neg", out_imm, 32'hFFFFFFFF);
        step(1, 32'hFE000EE3, 1, 0);
        chk("t2_beq_class", {28'b0, out_class}, {28'b0, CLS_BRANCH});
        chk("t2_beq_imm", out_imm, 32'hFFFFFFFC);

        step(1, 32'h00000833, 1, 0);
        chk("t3_x16_illegal", {31'b0, out_illegal}, 32'd1);
        chk("t3_x16_valid", {31'b0, out_valid}, 32'd1);
        step(1, 32'h00000001, 1, 0);
        chk("t3_compressed", {31'b0, out_illegal}, 32'd1);
        step(0, 32'h0, 1, 0);

        // Stall: three words offered while execute holds off.
        emitted = 0;
        step(1, 32'h00500093, 0, 0);
        step(1, 32'hFFF00093, 0, 0);
        chk("t4_in_ready_low", {31'b0, in_ready}, 32'd0);
        step(1, 32'hFE000EE3, 0, 0);
        step(1, 32'hFE000EE3, 0, 0);
        w3_acc = 0;
        for (int k = 0; k < 8 && !w3_acc; k++) begin
            w3_acc = (model_q.size() < 2);
            step(1, 32'hFE000EE3, 1, 0);
        end
        chk("t4_third_accepted", {31'b0, w3_acc}, 32'd1);
        in_valid = 1'b0;
        for (int k = 0; k < 8 && model_q.size() > 0; k++)
            step(0, 32'h0, 1, 0);
        chk("t4_emitted", emitted, 32'd3);
        chk("t4_empty", {31'b0, out_valid}, 32'd0);

        // Flush with main and skid full and an input offered.
        step(1, 32'h00500093, 0, 0);
        step(1, 32'hFFF00093, 0, 0);
        step(1, 32'hFE000EE3, 0, 1);
        chk("t5_out_valid", {31'b0, out_valid}, 32'd0);
        chk("t5_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (3) step(0, 32'h0, 1, 0);

        // Asynchronous reset mid-stall.
        step(1, 32'h00500093, 0, 0);
        step(1, 32'hFFF00093, 0, 0);
        in_valid = 1'b1; in_data = 32'hFE000EE3;
        #2 reset = 1'b0;
        #1;
        chk("t6_async_out_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_async_in_ready", {31'b0, in_ready}, 32'd1);
        chk("t6_async_imm", out_imm, 32'd0);
        model_q.delete();
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        step(1, 32'h00500093, 1, 0);
        chk("t6_post_class", {28'b0, out_class}, {28'b0, CLS_OP_IMM});
        chk("t6_post_imm", out_imm, 32'd5);
        step(0, 32'h0, 1, 0);

        // Random traffic; fetch holds a word until it is accepted.
        pend = 1'b0; pw = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && $urandom_range(0, 9) < 7) begin
                pend = 1'b1;
                pw = rand_word();
            end
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 49) == 0);
            acc  = pend && (model_q.size() < 2);
            step(pend, pw, ordy, fl);
            if (acc) pend = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
